// File: rtl/mdu_iter_if.sv
// mdu_iter_if
//   Groups the operation request, HI/LO results and status lines between the
//   EX stage and the iterative multiply/divide unit.
//   Request  (master -> slave): start, op_sel, a, b, flush, rd_hilo
//   Response (slave -> master): hi, lo, busy, done, stall
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             rd_hilo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op_sel, a, b, flush, rd_hilo,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op_sel, a, b, flush, rd_hilo,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter
//   Iterative multiply/divide unit of the EX stage. Owns HI/LO.
//   MULT/MULTU: radix-2 shift-add, WIDTH cycles, then one sign-fix cycle.
//   DIV/DIVU:   restoring division, WIDTH cycles, then one sign-fix cycle.
//   MTHI/MTLO:  single-cycle write from IDLE.
// Ports
//   clk   : core clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mdu_iter_if slave (start, op_sel, a, b, flush, rd_hilo in;
//           hi, lo, busy, done, stall out)
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mdu_iter_if.slave  bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Shared datapath: {accumulator, multiplier} for MUL,
  // {partial remainder, dividend/quotient} for DIV.
  logic [2*WIDTH-1:0] p_q, p_d;
  // Multiplicand magnitude for MUL, divisor magnitude for DIV.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               dz_q, dz_d;
  logic               div_q, div_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Operand magnitudes; op_sel[0]=0 selects the signed variants (MULT, DIV).
  logic             is_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    is_signed = ~bus.op_sel[0];
    a_neg     = is_signed & bus.a[WIDTH-1];
    b_neg     = is_signed & bus.b[WIDTH-1];
    mag_a     = a_neg ? -bus.a : bus.a;
    mag_b     = b_neg ? -bus.b : bus.b;
  end

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole pair right.
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  always_comb begin
    mul_addend = p_q[0] ? opnd_q : '0;
    mul_sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, p_q[WIDTH-1:1]};
  end

  // One restoring step: shift the next dividend bit into the remainder and
  // keep the trial difference only if it did not borrow (bit WIDTH clear).
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    div_shift = p_q[2*WIDTH-1:WIDTH-1];
    div_trial = div_shift - {1'b0, opnd_q};
    div_ok    = ~div_trial[WIDTH];
    div_next  = {(div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 p_q[WIDTH-2:0], div_ok};
  end

  // Sign correction; the remainder follows the dividend sign. The
  // most-negative overflow case falls out naturally since negating
  // 0x80..0 yields 0x80..0.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? -p_q : p_q;
    quo_fix  = (sa_q ^ sb_q) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    rem_fix  = sa_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    div_d   = div_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          case (bus.op_sel)
            3'd0, 3'd1: begin
              opnd_d  = mag_a;
              p_d     = {{WIDTH{1'b0}}, mag_b};
              sa_d    = a_neg;
              sb_d    = b_neg;
              dz_d    = 1'b0;
              div_d   = 1'b0;
              cnt_d   = '0;
              state_d = S_MUL;
            end
            3'd2, 3'd3: begin
              opnd_d  = mag_b;
              p_d     = {{WIDTH{1'b0}}, mag_a};
              sa_d    = a_neg;
              sb_d    = b_neg;
              dz_d    = (bus.b == '0);
              div_d   = 1'b1;
              cnt_d   = '0;
              state_d = S_DIV;
            end
            3'd4:    hi_d = bus.a;
            3'd5:    lo_d = bus.a;
            default: ;
          endcase
        end
      end

      S_MUL, S_DIV: begin
        if (bus.flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          p_d   = (state_q == S_MUL) ? mul_next : div_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_FIX;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (div_q) begin
            hi_d = rem_fix;
            lo_d = dz_q ? '1 : quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      div_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      div_q   <= div_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.stall = busy_q & (bus.rd_hilo | bus.start);

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter
//   Drives mdu_iter through its interface. Mult/div results are predicted by
//   a behavioural model when an op is launched, queued, and compared when
//   done pulses. Timing, MTHI/MTLO, stall, flush and reset cases are checked
//   directly.
module tb_mdu_iter;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  logic clk;
  logic reset;
  int   n_compared;
  int   n_mismatched;
  int   done_count;
  logic prev_done;
  hilo_t exp_q[$];

  mdu_iter_if #(.WIDTH(32)) bus ();

  mdu_iter #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour computed with plain 64-bit arithmetic.
  function automatic hilo_t model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
    hilo_t r;
    logic signed [63:0] sp;
    logic [63:0] up;
    r = '0;
    case (op)
      3'd0: begin
        sp = 64'($signed(a)) * 64'($signed(b));
        r  = sp;
      end
      3'd1: begin
        up = 64'(a) * 64'(b);
        r  = up;
      end
      3'd2: begin
        if (b == 32'd0) begin
          r.lo = 32'hFFFF_FFFF;
          r.hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.lo = 32'h8000_0000;
          r.hi = 32'd0;
        end else begin
          r.lo = 32'($signed(a) / $signed(b));
          r.hi = 32'($signed(a) % $signed(b));
        end
      end
      default: begin
        if (b == 32'd0) begin
          r.lo = 32'hFFFF_FFFF;
          r.hi = a;
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
      end
    endcase
    return r;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest queued result
  // and must last exactly one cycle.
  initial begin
    done_count = 0;
    prev_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        hilo_t e;
        done_count++;
        checkOutput("done_pulse_width", {63'd0, prev_done}, 64'd0);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_hi", {32'd0, bus.hi}, {32'd0, e.hi});
          checkOutput("sb_lo", {32'd0, bus.lo}, {32'd0, e.lo});
        end
      end
      prev_done = bus.done;
    end
  end

  // Launch one op once the unit is idle; start is seen at the next edge (E0).
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit expect_done);
    int guard;
    guard = 0;
    while (bus.busy === 1'b1 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("idle_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.op_sel = op;
    bus.a      = a;
    bus.b      = b;
    if (expect_done) exp_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Bounded wait for the next done pulse, observed at a falling edge.
  task automatic waitDone(input string tag);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (bus.done !== 1'b1 && guard < 100);
    if (bus.done !== 1'b1) checkOutput(tag, 64'd0, 64'd1);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.op_sel   = 3'd0;
    bus.a        = '0;
    bus.b        = '0;
    bus.flush    = 1'b0;
    bus.rd_hilo  = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_hi", {32'd0, bus.hi}, 64'd0);
    checkOutput("rst_lo", {32'd0, bus.lo}, 64'd0);
    checkOutput("rst_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("rst_done", {63'd0, bus.done}, 64'd0);
    reset = 1'b1;

    // MULTU all-ones with exact latency checks.
    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    checkOutput("multu_busy_e0", {63'd0, bus.busy}, 64'd1);
    repeat (32) @(posedge clk);
    #1;
    checkOutput("multu_busy_e32", {63'd0, bus.busy}, 64'd1);
    checkOutput("multu_hi_hold", {32'd0, bus.hi}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("multu_busy_e33", {63'd0, bus.busy}, 64'd0);
    checkOutput("multu_done_e33", {63'd0, bus.done}, 64'd1);
    checkOutput("multu_hi", {32'd0, bus.hi}, 64'hFFFF_FFFE);
    checkOutput("multu_lo", {32'd0, bus.lo}, 64'h0000_0001);
    @(posedge clk);
    #1;
    checkOutput("multu_done_e34", {63'd0, bus.done}, 64'd0);

    // Signed, divide-by-zero and overflow corners through the scoreboard.
    applyStimulus(3'd0, 32'hFFFF_FFF9, 32'd6, 1'b1);
    waitDone("to_mult");
    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    waitDone("to_div");
    applyStimulus(3'd3, 32'd100, 32'd0, 1'b1);
    waitDone("to_divu_zero");
    applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    waitDone("to_div_ovf");
    applyStimulus(3'd2, 32'hFFFF_FF00, 32'd0, 1'b1);
    waitDone("to_div_neg_zero");

    // MTHI / MTLO: written on the next edge, no busy, no done.
    applyStimulus(3'd4, 32'h1234_5678, 32'd0, 1'b0);
    checkOutput("mthi_hi", {32'd0, bus.hi}, 64'h1234_5678);
    checkOutput("mthi_busy", {63'd0, bus.busy}, 64'd0);
    applyStimulus(3'd5, 32'hCAFE_BABE, 32'd0, 1'b0);
    checkOutput("mtlo_lo", {32'd0, bus.lo}, 64'hCAFE_BABE);
    checkOutput("mtlo_hi", {32'd0, bus.hi}, 64'h1234_5678);
    checkOutput("mtlo_done", {63'd0, bus.done}, 64'd0);

    // Reserved op does nothing.
    applyStimulus(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
    @(negedge clk);
    checkOutput("rsv_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("rsv_hi", {32'd0, bus.hi}, 64'h1234_5678);
    checkOutput("rsv_lo", {32'd0, bus.lo}, 64'hCAFE_BABE);

    // DIVU in flight: stall raised, second start ignored, HI/LO held.
    applyStimulus(3'd3, 32'd1000, 32'd7, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    bus.rd_hilo = 1'b1;
    bus.start   = 1'b1;
    bus.op_sel  = 3'd1;
    bus.a       = 32'd2;
    bus.b       = 32'd2;
    #1;
    checkOutput("busy_stall", {63'd0, bus.stall}, 64'd1);
    checkOutput("busy_hi_hold", {32'd0, bus.hi}, 64'h1234_5678);
    checkOutput("busy_lo_hold", {32'd0, bus.lo}, 64'hCAFE_BABE);
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.rd_hilo = 1'b0;
    waitDone("to_divu_inflight");
    #1;
    bus.rd_hilo = 1'b1;
    #1;
    checkOutput("idle_stall", {63'd0, bus.stall}, 64'd0);
    bus.rd_hilo = 1'b0;

    // Flush of a MULT at cycle 20: idle next edge, HI/LO keep DIVU result.
    applyStimulus(3'd0, 32'd5, 32'd9, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    checkOutput("flush_busy", {63'd0, bus.busy}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("flush_hi", {32'd0, bus.hi}, 64'd6);
    checkOutput("flush_lo", {32'd0, bus.lo}, 64'd142);

    // Flush together with start in IDLE: start ignored.
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    bus.op_sel = 3'd1;
    bus.a      = 32'd3;
    bus.b      = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checkOutput("flush_start_busy", {63'd0, bus.busy}, 64'd0);

    // Asynchronous reset in the middle of a DIV.
    applyStimulus(3'd2, 32'hFFFF_FF9C, 32'd3, 1'b0);
    repeat (15) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("arst_hi", {32'd0, bus.hi}, 64'd0);
    checkOutput("arst_lo", {32'd0, bus.lo}, 64'd0);
    checkOutput("arst_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(3'd1, 32'd3, 32'd5, 1'b1);
    waitDone("to_multu_after_rst");

    // A few random operations, including a zero divisor.
    for (int i = 0; i < 6; i++) begin
      logic [2:0]  op;
      logic [31:0] ra;
      logic [31:0] rb;
      op = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 2) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      applyStimulus(op, ra, rb, 1'b1);
      waitDone("to_random");
    end

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
